// File: rtl/rc4_pkg.sv
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types and constants for the RC4 stream XOR block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

  localparam int c_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RUN  = 2'd3
  } rc4_state_e;

endpackage

`default_nettype wire

// File: rtl/rc4_done_edge.sv
// ============================================================================
// Module      : rc4_done_edge
// Description : Synchronous rising-edge detector for the generator done level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_done_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic done,
  output logic rise
);

  logic r_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= done;
    end
  end

  assign rise = done & ~r_done_q;

endmodule

`default_nettype wire

// File: rtl/rc4_stream_xor.sv
// ============================================================================
// Module      : rc4_stream_xor
// Description : Requests RC4 keystream blocks and XORs them with a byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int NUMS_OF_BYTES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  output logic                                ks_start,
  input  logic [NUMS_OF_BYTES*c_BYTE_W-1:0]   ks_data,
  input  logic                                ks_done,
  input  logic                                pt_valid,
  input  logic [c_BYTE_W-1:0]                 pt_data,
  output logic                                pt_ready,
  output logic                                ct_valid,
  output logic [c_BYTE_W-1:0]                 ct_data,
  input  logic                                ct_ready,
  output logic                                busy,
  output logic [15:0]                         blk_cnt
);

  localparam int                 c_IDX_W    = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUMS_OF_BYTES - 1);

  rc4_state_e                          r_state;
  rc4_state_e                          w_state_nxt;
  logic [NUMS_OF_BYTES*c_BYTE_W-1:0]   r_buf;
  logic [c_IDX_W-1:0]                  r_idx;
  logic                                r_ct_valid;
  logic [c_BYTE_W-1:0]                 r_ct_data;
  logic [15:0]                         r_blk_cnt;
  logic                                w_rise;
  logic                                w_pt_ready;
  logic                                w_pt_fire;
  logic                                w_last;
  logic [c_BYTE_W-1:0]                 w_ks_byte;

  rc4_done_edge u_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .done  (ks_done),
    .rise  (w_rise)
  );

  assign w_ks_byte = r_buf[r_idx*c_BYTE_W +: c_BYTE_W];
  assign w_last    = (r_idx == c_LAST_IDX);
  assign w_pt_fire = pt_valid & w_pt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // en is only consulted in IDLE and on the final byte of a block
  always_comb begin
    w_state_nxt = r_state;
    ks_start    = 1'b0;
    w_pt_ready  = 1'b0;
    case (r_state)
      IDLE: if (en) w_state_nxt = REQ;
      REQ: begin
        ks_start    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (w_rise) w_state_nxt = RUN;
      RUN: begin
        w_pt_ready = !r_ct_valid || ct_ready;
        if (pt_valid && w_pt_ready && w_last) begin
          w_state_nxt = en ? REQ : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_ct_valid <= 1'b0;
      r_ct_data  <= '0;
      r_blk_cnt  <= '0;
    end else begin
      if ((r_state == WAIT) && w_rise) begin
        r_buf <= ks_data;
        r_idx <= '0;
      end
      // a fill in the same cycle as a drain keeps the output valid
      if (w_pt_fire) begin
        r_ct_data  <= pt_data ^ w_ks_byte;
        r_ct_valid <= 1'b1;
        r_idx      <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_blk_cnt <= r_blk_cnt + 16'd1;
        end
      end else if (r_ct_valid && ct_ready) begin
        r_ct_valid <= 1'b0;
      end
    end
  end

  assign pt_ready = w_pt_ready;
  assign ct_valid = r_ct_valid;
  assign ct_data  = r_ct_data;
  assign busy     = (r_state != IDLE);
  assign blk_cnt  = r_blk_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rc4_stream_xor.sv
// ============================================================================
// Module      : tb_rc4_stream_xor
// Description : Directed self-checking bench for rc4_stream_xor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_stream_xor;

  localparam int NB = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [31:0] ks_data  = '0;
  logic        ks_done  = 1'b0;
  logic        pt_valid = 1'b0;
  logic [7:0]  pt_data  = '0;
  logic        ct_ready = 1'b1;
  logic        ks_start;
  logic        pt_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        busy;
  logic [15:0] blk_cnt;

  rc4_stream_xor #(.NUMS_OF_BYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ks_start (ks_start),
    .ks_data  (ks_data),
    .ks_done  (ks_done),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .pt_ready (pt_ready),
    .ct_valid (ct_valid),
    .ct_data  (ct_data),
    .ct_ready (ct_ready),
    .busy     (busy),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_start = 0, gen_cnt = 0, ks_idx = 0;
  int pt_pos = 0, ct_pos = 0, pt_len = 0, stall_left = 0, en_drop_at = -1;
  bit gen_on = 1'b1, hold_done = 1'b0;
  logic [31:0] ks_tab [4];
  logic [7:0]  pt_q   [16];
  logic [7:0]  exp_q  [16];
  int          acc_cyc[16];
  int          ct_cyc [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] p, input logic [7:0] e);
    pt_q[i]  = p;
    exp_q[i] = e;
  endtask

  task automatic new_test();
    pt_pos = 0; ct_pos = 0; ks_idx = 0; n_start = 0;
    stall_left = 0; en_drop_at = -1; gen_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      acc_cyc[i] = 0;
      ct_cyc[i]  = 0;
    end
  endtask

  // One cycle: drive at the falling edge, then observe the handshakes that
  // the next rising edge will complete.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (gen_cnt == 1) begin
      ks_data = ks_tab[ks_idx];
      ks_done = 1'b1;
      ks_idx++;
    end else if (!hold_done) begin
      ks_done = 1'b0;
    end
    if (gen_cnt > 0) gen_cnt--;
    if (en_drop_at >= 0 && pt_pos >= en_drop_at) en = 1'b0;
    pt_valid = (pt_pos < pt_len);
    pt_data  = 8'h00;
    if (pt_valid) pt_data = pt_q[pt_pos];
    ct_ready = 1'b1;
    if (ct_valid && ct_pos == 0 && stall_left > 0) begin
      ct_ready = 1'b0;
      stall_left--;
    end
    #1;
    if (ks_start) begin
      n_start++;
      if (gen_on) gen_cnt = 2;
    end
    if (ct_valid && !ct_ready) begin
      check_val("stall_ct_hold", ct_data, exp_q[ct_pos]);
      check_val("stall_pt_ready", pt_ready, 0);
    end
    if (ct_valid && ct_ready) begin
      if (ct_pos < pt_len) begin
        check_val($sformatf("ct_byte%0d", ct_pos), ct_data, exp_q[ct_pos]);
        ct_cyc[ct_pos] = cyc;
      end else begin
        check_val("ct_extra", ct_pos, pt_len);
      end
      ct_pos++;
    end
    if (pt_valid && pt_ready) begin
      acc_cyc[pt_pos] = cyc;
      pt_pos++;
    end
  endtask

  task automatic run_until(input int n, input int bound);
    int k = 0;
    while (ct_pos < n && k < bound) begin
      tick();
      k++;
    end
    check_val("ct_count", ct_pos, n);
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    check_val("rst_ks_start", ks_start, 0);
    check_val("rst_pt_ready", pt_ready, 0);
    check_val("rst_ct_valid", ct_valid, 0);
    check_val("rst_ct_data", ct_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_blk_cnt", blk_cnt, 0);
    rst_n = 1'b1;

    // basic block
    new_test();
    ks_tab[0] = 32'hA4B3C2D1;
    set_byte(0, 8'h00, 8'hD1); set_byte(1, 8'h11, 8'hD3);
    set_byte(2, 8'h22, 8'h91); set_byte(3, 8'h33, 8'h97);
    pt_len = 4; en_drop_at = 1; en = 1'b1;
    run_until(4, 40);
    check_val("basic_latency", ct_cyc[0] - acc_cyc[0], 1);
    check_val("basic_back2back", ct_cyc[3] - ct_cyc[0], 3);
    repeat (4) tick();
    check_val("basic_blk_cnt", blk_cnt, 1);
    check_val("basic_starts", n_start, 1);
    check_val("basic_idle", busy, 0);

    // backpressure on the first output byte
    new_test();
    stall_left = 3; en_drop_at = 1; en = 1'b1;
    run_until(4, 40);
    check_val("bp_stall_len", ct_cyc[0] - acc_cyc[0], 4);
    repeat (4) tick();
    check_val("bp_blk_cnt", blk_cnt, 2);
    check_val("bp_starts", n_start, 1);

    // done already high before the request
    new_test();
    gen_on = 1'b0; hold_done = 1'b1; ks_done = 1'b1; ks_data = 32'hDEADBEEF;
    set_byte(0, 8'h10, 8'h1C); set_byte(1, 8'h20, 8'h2D);
    set_byte(2, 8'h30, 8'h3E); set_byte(3, 8'h40, 8'h4F);
    en_drop_at = 1; en = 1'b1;
    repeat (6) begin
      tick();
      check_val("stale_pt_ready", pt_ready, 0);
    end
    check_val("stale_busy", busy, 1);
    ks_done = 1'b0; ks_data = 32'h0F0E0D0C;
    repeat (2) tick();
    check_val("stale_low_pt_ready", pt_ready, 0);
    ks_done = 1'b1; hold_done = 1'b0;
    run_until(4, 20);
    gen_on = 1'b1;
    repeat (3) tick();
    check_val("stale_blk_cnt", blk_cnt, 3);
    check_val("stale_starts", n_start, 1);

    // three blocks back to back, en dropped after byte 1 of the last block
    new_test();
    ks_tab[0] = 32'h44332211; ks_tab[1] = 32'h80402010; ks_tab[2] = 32'hFFFFFFFF;
    set_byte(0, 8'hAA, 8'hBB); set_byte(1, 8'hBB, 8'h99);
    set_byte(2, 8'hCC, 8'hFF); set_byte(3, 8'hDD, 8'h99);
    set_byte(4, 8'h01, 8'h11); set_byte(5, 8'h02, 8'h22);
    set_byte(6, 8'h03, 8'h43); set_byte(7, 8'h04, 8'h84);
    set_byte(8, 8'h00, 8'hFF); set_byte(9, 8'h5A, 8'hA5);
    set_byte(10, 8'hA5, 8'h5A); set_byte(11, 8'hFF, 8'h00);
    pt_len = 12; en_drop_at = 10; en = 1'b1;
    run_until(12, 120);
    repeat (6) tick();
    check_val("multi_blk_cnt", blk_cnt, 6);
    check_val("multi_starts", n_start, 3);
    check_val("multi_idle", busy, 0);
    check_val("multi_pt_taken", pt_pos, 12);

    // asynchronous reset while an output byte is pending
    new_test();
    ks_tab[0] = 32'h000000FF;
    set_byte(0, 8'h01, 8'hFE);
    pt_len = 1; stall_left = 100; en = 1'b1;
    for (int k = 0; k < 20 && !ct_valid; k++) tick();
    check_val("arst_pre_ct_valid", ct_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_ct_valid", ct_valid, 0);
    check_val("arst_ct_data", ct_data, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_blk_cnt", blk_cnt, 0);
    check_val("arst_pt_ready", pt_ready, 0);
    check_val("arst_ks_start", ks_start, 0);
    en = 1'b0; gen_cnt = 0; ks_done = 1'b0; hold_done = 1'b0; stall_left = 0; pt_len = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    new_test();
    ks_tab[0] = 32'h12345678;
    set_byte(0, 8'h00, 8'h78); set_byte(1, 8'h01, 8'h57);
    set_byte(2, 8'h02, 8'h36); set_byte(3, 8'h03, 8'h11);
    pt_len = 4; en_drop_at = 1; en = 1'b1;
    tick();
    check_val("arst_restart_req", ks_start, 1);
    check_val("arst_restart_cnt", blk_cnt, 0);
    run_until(4, 40);
    repeat (3) tick();
    check_val("arst_final_cnt", blk_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
